// File: rtl/usb_tx_bit_encoder.sv
// Byte-to-line-symbol encoder: LSB-first serialise, bit stuff, NRZI, EOP; one symbol per wire-buffer write.
// Optional USB_TX_AUTO_SYNC_EN: SOP command prepends the 8'h80 SYNC byte ahead of the supplied PID.
module usb_tx_bit_encoder #(
  parameter int STUFF_LIMIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic [1:0] tx_cmd,
  input  logic       tx_wen,
  output logic       tx_rdy,
  input  logic       full_speed_polarity,
  input  logic       usb_wire_rdy,
  output logic       usb_wire_wen,
  output logic [1:0] usb_wire_bits,
  output logic       usb_wire_ctrl,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_STUFF,
    S_EOP0,
    S_EOP1,
    S_EOPJ
  } state_t;

`ifdef USB_TX_AUTO_SYNC_EN
  localparam int SR_W = 16;
`else
  localparam int SR_W = 8;
`endif

  state_t          r_state;
  logic [SR_W-1:0] r_sr;
  logic [4:0]      r_left;
  logic [2:0]      r_ones;
  logic            r_lvl;
  logic            r_rdy;
  logic            r_wen;
  logic [1:0]      r_bits;
  logic            r_ctrl;
  logic            r_busy;

  logic            w_accept;
  logic            w_go;
  logic [1:0]      w_j;
  logic            w_shift_lvl;
  logic [2:0]      w_shift_ones;
  logic [SR_W-1:0] w_load_sr;
  logic [4:0]      w_load_left;

  function automatic logic [1:0] f_sym(input logic lvl, input logic [1:0] j);
    return lvl ? j : ~j;
  endfunction

  assign w_accept     = tx_wen & r_rdy;
  // The wen-low requirement absorbs the wire buffer's one-cycle Rdy drop latency.
  assign w_go         = usb_wire_rdy & ~r_wen;
  assign w_j          = full_speed_polarity ? 2'b10 : 2'b01;
  assign w_shift_lvl  = r_sr[0] ? r_lvl : ~r_lvl;
  assign w_shift_ones = r_sr[0] ? r_ones + 3'd1 : 3'd0;

`ifdef USB_TX_AUTO_SYNC_EN
  assign w_load_sr   = (tx_cmd == 2'b01) ? {tx_byte, 8'h80} : {8'h00, tx_byte};
  assign w_load_left = (tx_cmd == 2'b01) ? 5'd16 : 5'd8;
`else
  assign w_load_sr   = tx_byte;
  assign w_load_left = 5'd8;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_left  <= '0;
      r_ones  <= '0;
      r_lvl   <= 1'b1;
      r_rdy   <= 1'b0;
      r_wen   <= 1'b0;
      r_bits  <= 2'b00;
      r_ctrl  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_ctrl <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            r_rdy <= 1'b0;
            case (tx_cmd)
              2'b01: begin
                r_lvl   <= 1'b1;
                r_ones  <= '0;
                r_sr    <= w_load_sr;
                r_left  <= w_load_left;
                r_busy  <= 1'b1;
                r_state <= S_SHIFT;
              end
              2'b00: begin
                r_sr    <= w_load_sr;
                r_left  <= w_load_left;
                r_busy  <= 1'b1;
                r_state <= S_SHIFT;
              end
              2'b10: begin
                r_busy  <= 1'b1;
                r_state <= S_EOP0;
              end
              default: ;
            endcase
          end
        end
        S_SHIFT: if (w_go) begin
          r_wen  <= 1'b1;
          r_ctrl <= 1'b1;
          r_bits <= f_sym(w_shift_lvl, w_j);
          r_lvl  <= w_shift_lvl;
          r_ones <= w_shift_ones;
          r_sr   <= r_sr >> 1;
          r_left <= r_left - 5'd1;
          // A stuff owed after the last bit is still sent before going idle.
          if (w_shift_ones == 3'(STUFF_LIMIT)) begin
            r_state <= S_STUFF;
          end else if (r_left == 5'd1) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_STUFF: if (w_go) begin
          r_wen  <= 1'b1;
          r_ctrl <= 1'b1;
          r_bits <= f_sym(~r_lvl, w_j);
          r_lvl  <= ~r_lvl;
          r_ones <= '0;
          if (r_left == 5'd0) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_EOP0: if (w_go) begin
          r_wen   <= 1'b1;
          r_ctrl  <= 1'b1;
          r_bits  <= 2'b00;
          r_state <= S_EOP1;
        end
        S_EOP1: if (w_go) begin
          r_wen   <= 1'b1;
          r_ctrl  <= 1'b1;
          r_bits  <= 2'b00;
          r_state <= S_EOPJ;
        end
        S_EOPJ: if (w_go) begin
          r_wen   <= 1'b1;
          r_ctrl  <= 1'b1;
          r_bits  <= w_j;
          r_lvl   <= 1'b1;
          r_ones  <= '0;
          r_state <= S_IDLE;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_rdy        = r_rdy;
  assign usb_wire_wen  = r_wen;
  assign usb_wire_bits = r_bits;
  assign usb_wire_ctrl = r_ctrl;
  // Covers the accept cycle and the cycle in which the final symbol is written.
  assign busy          = r_busy | r_wen | w_accept;

endmodule
